// File: rtl/master_cmd_pkg.sv
// Shared types and default widths for the master command queue.
package master_cmd_pkg;

  localparam int DEF_SLAVE_LEN   = 2;
  localparam int DEF_ADDRESS_LEN = 12;
  localparam int DEF_WORD_SIZE   = 8;
  localparam int DEF_BURST_SIZE  = 12;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_TIMEOUT     = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Command layout at the default widths; the queue packs fields in this order.
  typedef struct packed {
    logic                      write;
    logic [DEF_WORD_SIZE-1:0]   data;
    logic [DEF_ADDRESS_LEN-1:0] address;
    logic [DEF_SLAVE_LEN-1:0]   slave;
    logic [DEF_BURST_SIZE:0]    burst;
  } cmd_t;

  // Bits in one packed command for a given set of field widths.
  function automatic int cmd_width(input int word_size, input int address_len,
                                   input int slave_len, input int burst_size);
    return 1 + word_size + address_len + slave_len + burst_size + 1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: wrap-around pointers, occupancy counter, head read combinationally.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                   i_clock,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  // A push while full and a pop while empty are silently dropped.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Write the incoming command at the write pointer.
  // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Advance pointers (natural wrap, DEPTH is a power of 2) and track occupancy.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/master_cmd_queue.sv
// Queues host commands and hands them one at a time to a bus master, with
// busy-handshake tracking, completion pulse and busy-wait timeout.
module master_cmd_queue
  import master_cmd_pkg::*;
#(
  parameter int SLAVE_LEN   = DEF_SLAVE_LEN,
  parameter int ADDRESS_LEN = DEF_ADDRESS_LEN,
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int BURST_SIZE  = DEF_BURST_SIZE,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   i_clock,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_write,
  input  logic [WORD_SIZE-1:0]   i_cmd_data,
  input  logic [ADDRESS_LEN-1:0] i_cmd_address,
  input  logic [SLAVE_LEN-1:0]   i_cmd_slave,
  input  logic [BURST_SIZE:0]    i_cmd_burst,
  output logic                   o_read,
  output logic                   o_write,
  output logic [WORD_SIZE-1:0]   o_data,
  output logic [ADDRESS_LEN-1:0] o_address,
  output logic [SLAVE_LEN-1:0]   o_slave,
  output logic [BURST_SIZE:0]    o_burst_num,
  input  logic                   i_m_busy,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_done,
  output logic                   o_timeout_err
);

  localparam int CMD_W = cmd_width(WORD_SIZE, ADDRESS_LEN, SLAVE_LEN, BURST_SIZE);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_wait_cnt;
  logic                   r_read;
  logic                   r_write;
  logic                   r_done;
  logic                   r_timeout_err;
  logic [WORD_SIZE-1:0]   r_data;
  logic [ADDRESS_LEN-1:0] r_address;
  logic [SLAVE_LEN-1:0]   r_slave;
  logic [BURST_SIZE:0]    r_burst;

  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  logic [CMD_W-1:0]       w_push_word;
  logic [CMD_W-1:0]       w_head_word;
  logic                   w_head_write;
  logic [WORD_SIZE-1:0]   w_head_data;
  logic [ADDRESS_LEN-1:0] w_head_address;
  logic [SLAVE_LEN-1:0]   w_head_slave;
  logic [BURST_SIZE:0]    w_head_burst;
  logic [CNT_W-1:0]       w_wait_next;

  assign w_push_word = {i_cmd_write, i_cmd_data, i_cmd_address, i_cmd_slave, i_cmd_burst};
  assign {w_head_write, w_head_data, w_head_address, w_head_slave, w_head_burst} = w_head_word;

  // Only an idle controller with an enabled, non-busy master takes the head entry.
  assign w_pop       = (r_state == IDLE) && !w_empty && i_enable && !i_m_busy;
  assign w_wait_next = r_wait_cnt + 1'b1;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clock (i_clock),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_pop   (w_pop),
    .i_wdata (w_push_word),
    .o_rdata (w_head_word),
    .o_count (o_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Issue FSM with registered strobes, pulses and held command fields.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_data        <= '0;
      r_address     <= '0;
      r_slave       <= '0;
      r_burst       <= '0;
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below.
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_data    <= w_head_data;
            r_address <= w_head_address;
            r_slave   <= w_head_slave;
            r_burst   <= w_head_burst;
            r_write   <= w_head_write;
            r_read    <= !w_head_write;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_m_busy) begin
            r_state <= WAIT_DONE;
          end else if (w_wait_next == CNT_W'(TIMEOUT)) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        WAIT_DONE: begin
          if (!i_m_busy) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready   = !w_full;
  assign o_empty       = w_empty;
  assign o_full        = w_full;
  assign o_read        = r_read;
  assign o_write       = r_write;
  assign o_done        = r_done;
  assign o_timeout_err = r_timeout_err;
  assign o_data        = r_data;
  assign o_address     = r_address;
  assign o_slave       = r_slave;
  assign o_burst_num   = r_burst;

endmodule

// File: tb/tb_master_cmd_queue.sv
// Scoreboard bench: drivers push expected commands/completions into queues,
// a monitor compares every cycle against a queue-level reference model.
module tb_master_cmd_queue;
  import master_cmd_pkg::*;

  localparam int DEPTH   = DEF_DEPTH;
  localparam int TIMEOUT = DEF_TIMEOUT;

  logic                       i_clock = 1'b0;
  logic                       i_rst = 1'b1;
  logic                       i_enable = 1'b0;
  logic                       i_cmd_valid = 1'b0;
  logic                       i_cmd_write = 1'b0;
  logic [DEF_WORD_SIZE-1:0]   i_cmd_data = '0;
  logic [DEF_ADDRESS_LEN-1:0] i_cmd_address = '0;
  logic [DEF_SLAVE_LEN-1:0]   i_cmd_slave = '0;
  logic [DEF_BURST_SIZE:0]    i_cmd_burst = '0;
  logic                       i_m_busy = 1'b0;
  logic                       o_cmd_ready, o_read, o_write, o_empty, o_full, o_done, o_timeout_err;
  logic [DEF_WORD_SIZE-1:0]   o_data;
  logic [DEF_ADDRESS_LEN-1:0] o_address;
  logic [DEF_SLAVE_LEN-1:0]   o_slave;
  logic [DEF_BURST_SIZE:0]    o_burst_num;
  logic [$clog2(DEPTH):0]     o_count;

  master_cmd_queue #(
    .SLAVE_LEN(DEF_SLAVE_LEN), .ADDRESS_LEN(DEF_ADDRESS_LEN), .WORD_SIZE(DEF_WORD_SIZE),
    .BURST_SIZE(DEF_BURST_SIZE), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clock(i_clock), .i_rst(i_rst), .i_enable(i_enable),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_data(i_cmd_data), .i_cmd_address(i_cmd_address), .i_cmd_slave(i_cmd_slave),
    .i_cmd_burst(i_cmd_burst), .o_read(o_read), .o_write(o_write), .o_data(o_data),
    .o_address(o_address), .o_slave(o_slave), .o_burst_num(o_burst_num),
    .i_m_busy(i_m_busy), .o_count(o_count), .o_empty(o_empty), .o_full(o_full),
    .o_done(o_done), .o_timeout_err(o_timeout_err)
  );

  always #5 i_clock = ~i_clock;

  typedef struct { bit is_done; int cyc; } evt_t;

  cmd_t exp_q[$];          // commands expected to be issued, in order
  evt_t evt_q[$];          // expected done/timeout pulses with their cycle
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   model_count = 0;
  bit   inflight = 1'b0;
  bit   prev_idle = 1'b1;
  int   prev_cnt = 0;
  cmd_t last = '0;
  bit   bus_auto = 1'b0;
  bit   force_timeout = 1'b0;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.write   = 1'($urandom_range(0, 1));
    c.data    = DEF_WORD_SIZE'($urandom);
    c.address = DEF_ADDRESS_LEN'($urandom);
    c.slave   = DEF_SLAVE_LEN'($urandom);
    c.burst   = (DEF_BURST_SIZE+1)'($urandom);
    return c;
  endfunction

  // One input cycle; an accepted push is recorded as an expected issue.
  task automatic drive_cycle(input bit v, input bit en, input cmd_t c);
    @(negedge i_clock);
    i_cmd_valid   = v;
    i_enable      = en;
    i_cmd_write   = c.write;
    i_cmd_data    = c.data;
    i_cmd_address = c.address;
    i_cmd_slave   = c.slave;
    i_cmd_burst   = c.burst;
    @(posedge i_clock);
    if (!i_rst && v && model_count < DEPTH) begin
      exp_q.push_back(c);
      model_count++;
    end
  endtask

  // Bus master answers strobe at cycle s: low d more cycles, busy for len cycles.
  task automatic serve_done(input int s, input int d, input int len);
    evt_q.push_back('{1'b1, s + d + len + 2});
    forever begin
      @(negedge i_clock);
      i_m_busy = (cyc >= s + d + 1) && (cyc <= s + d + len);
      if (cyc >= s + d + len + 1) break;
    end
  endtask

  // Bus master never answers in time; optionally raises busy just after the window.
  task automatic serve_timeout(input int s, input int late);
    evt_q.push_back('{1'b0, s + TIMEOUT + 1});
    while (late > 0) begin
      @(negedge i_clock);
      i_m_busy = (cyc >= s + TIMEOUT + 1) && (cyc <= s + TIMEOUT + late);
      if (cyc > s + TIMEOUT + late) break;
    end
  endtask

  // Called right at a rising edge; returns the cycle in which a strobe is seen.
  task automatic wait_strobe(output int s);
    s = -1;
    #1;
    for (int i = 0; i < 64 && s < 0; i++) begin
      if (o_read || o_write) s = cyc;
      else begin
        @(posedge i_clock);
        #1;
      end
    end
    if (s < 0) begin
      total++;
      bad++;
      $display("FAIL strobe_wait: no strobe within 64 cycles");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() > 0 || inflight || evt_q.size() > 0) && n < 2000) begin
      @(posedge i_clock);
      n++;
    end
    @(negedge i_clock);
    check("drain", exp_q.size() + evt_q.size() + int'(inflight), 0);
  endtask

  // Automatic bus-master responder.
  initial begin : responder
    int s, r;
    forever begin
      @(posedge i_clock);
      #1;
      if (bus_auto && !i_rst && (o_read || o_write)) begin
        s = cyc;
        r = $urandom_range(0, 9);
        if (force_timeout) serve_timeout(s, 0);
        else if (r >= 7) serve_timeout(s, (r == 9) ? $urandom_range(1, 3) : 0);
        else serve_done(s, (r == 0) ? TIMEOUT - 1 : $urandom_range(0, 4), $urandom_range(1, 4));
      end
    end
  end

  // Monitor: compares the DUT every cycle against the queue-level model.
  initial begin : monitor
    bit strobe, exp_strobe, exp_done, exp_to;
    cmd_t head;
    forever begin
      @(posedge i_clock);
      #1;
      check("read_and_write", o_read && o_write, 1'b0);
      if (i_rst) begin
        exp_q.delete();
        evt_q.delete();
        model_count = 0;
        inflight    = 1'b0;
        last        = '0;
        check("rst_read", o_read, 1'b0);
        check("rst_write", o_write, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_timeout", o_timeout_err, 1'b0);
        check("rst_state", dut.r_state, IDLE);
      end else begin
        strobe     = o_read || o_write;
        exp_strobe = prev_idle && (prev_cnt > 0) && i_enable && !i_m_busy;
        check("issue", strobe, exp_strobe);
        if (strobe) begin
          check("cmd_avail", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            head = exp_q.pop_front();
            check("kind", o_write, head.write);
            last = head;
            model_count--;
            inflight = 1'b1;
          end
        end
        exp_done = 1'b0;
        exp_to   = 1'b0;
        if (evt_q.size() > 0 && evt_q[0].cyc == cyc) begin
          exp_done = evt_q[0].is_done;
          exp_to   = !evt_q[0].is_done;
        end
        check("done", o_done, exp_done);
        check("timeout_err", o_timeout_err, exp_to);
        if (evt_q.size() > 0 && evt_q[0].cyc <= cyc) begin
          void'(evt_q.pop_front());
          inflight = 1'b0;
        end
      end
      check("fields", {o_data, o_address, o_slave, o_burst_num},
            {last.data, last.address, last.slave, last.burst});
      check("count", o_count, model_count);
      check("empty", o_empty, model_count == 0);
      check("full", o_full, model_count == DEPTH);
      check("cmd_ready", o_cmd_ready, model_count < DEPTH);
      prev_idle = !inflight;
      prev_cnt  = model_count;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    cmd_t c;
    int   s, drop;
    repeat (3) @(negedge i_clock);
    i_rst = 1'b0;

    // Single write, busy high for 3 cycles after the strobe.
    c = '{write: 1'b1, data: 8'd120, address: 12'h042, slave: 2'd0, burst: 13'd0};
    drive_cycle(1'b1, 1'b1, c);
    drive_cycle(1'b0, 1'b1, c);
    wait_strobe(s);
    check("write_strobe", o_write, 1'b1);
    serve_done(s, 0, 3);
    wait_drain();

    // Fill with issue disabled; fifth push is ignored; then release.
    bus_auto = 1'b1;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, rand_cmd());
    drive_cycle(1'b0, 1'b0, rand_cmd());
    #1;
    check("full_flag", o_full, 1'b1);
    check("ready_when_full", o_cmd_ready, 1'b0);
    drive_cycle(1'b0, 1'b1, rand_cmd());
    wait_drain();

    // Read with busy never answered, then a normal command.
    force_timeout = 1'b1;
    c = rand_cmd();
    c.write = 1'b0;
    drive_cycle(1'b1, 1'b1, c);
    drive_cycle(1'b0, 1'b1, c);
    wait_strobe(s);
    check("read_strobe", o_read, 1'b1);
    @(negedge i_clock);
    force_timeout = 1'b0;
    wait_drain();
    drive_cycle(1'b1, 1'b1, rand_cmd());
    drive_cycle(1'b0, 1'b1, rand_cmd());
    wait_drain();

    // Simultaneous push and pop at count 2, then wrap with 10 commands.
    drive_cycle(1'b1, 1'b0, rand_cmd());
    drive_cycle(1'b1, 1'b0, rand_cmd());
    drive_cycle(1'b1, 1'b1, rand_cmd());
    #1;
    check("push_pop_count", o_count, 2);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b1, rand_cmd());
      drive_cycle(1'b0, 1'b1, rand_cmd());
    end
    wait_drain();

    // Reset while waiting for done with 3 entries queued.
    bus_auto = 1'b0;
    drive_cycle(1'b1, 1'b1, rand_cmd());
    drive_cycle(1'b0, 1'b1, rand_cmd());
    wait_strobe(s);
    @(negedge i_clock);
    i_m_busy = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, rand_cmd());
    drive_cycle(1'b0, 1'b1, rand_cmd());
    #1;
    check("queued_before_rst", o_count, 3);
    check("state_before_rst", dut.r_state, WAIT_DONE);
    @(negedge i_clock);
    i_rst = 1'b1;
    @(negedge i_clock);
    i_rst    = 1'b0;
    i_m_busy = 1'b0;
    check("empty_after_rst", o_empty, 1'b1);

    // Busy held at idle blocks issue until it drops.
    @(negedge i_clock);
    i_m_busy = 1'b1;
    drive_cycle(1'b1, 1'b1, rand_cmd());
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, rand_cmd());
    @(negedge i_clock);
    i_m_busy = 1'b0;
    drop = cyc;
    wait_strobe(s);
    check("busy_release_latency", s - drop, 1);
    serve_done(s, 1, 1);
    wait_drain();

    // Randomised traffic with enable toggling.
    bus_auto = 1'b1;
    for (int i = 0; i < 400; i++)
      drive_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, rand_cmd());
    drive_cycle(1'b0, 1'b1, rand_cmd());
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
